// File: rtl/keypad_event_encoder_pkg.sv
// rtl/keypad_event_encoder_pkg.sv - shared FSM encodings and default parameters for the keypad encoder
package keypad_event_encoder_pkg;

    // Default build of the encoder: ten keys, 4-bit codes, 4-cycle debounce, 4-entry event FIFO
    localparam int DEF_N_KEYS   = 10;
    localparam int DEF_CODE_W   = 4;
    localparam int DEF_DEBOUNCE = 4;
    localparam int DEF_DEPTH    = 4;

    // Press/hold/release debouncer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/keypad_event_encoder_sync_fifo.sv
// rtl/keypad_event_encoder_sync_fifo.sv - circular event FIFO with drop-on-full pulse
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             r_drop;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd];
    assign drop  = r_drop;

    // A push into a full FIFO still lands if the head is leaving in the same cycle
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Storage, pointers (wrap naturally at DEPTH) and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_drop <= push && full && !w_do_pop;
        end
    end

endmodule

// File: rtl/keypad_event_encoder.sv
// rtl/keypad_event_encoder.sv - synchronised, debounced keypad priority encoder feeding an event FIFO
module keypad_event_encoder
    import keypad_event_encoder_pkg::*;
#(
    parameter int N_KEYS   = DEF_N_KEYS,
    parameter int CODE_W   = DEF_CODE_W,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enablen,
    input  logic [N_KEYS-1:0] keypad,
    output logic [CODE_W-1:0] D,
    output logic              V,
    input  logic              ready,
    output logic              pressed,
    output logic              overflow
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_ks;
    logic              w_any;
    logic [CODE_W-1:0] w_cand;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CODE_W-1:0] r_cand;
    logic [CODE_W-1:0] w_cand_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    // Two-flop synchroniser for the asynchronous key lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_ks    <= '0;
        end else begin
            r_sync1 <= keypad;
            r_ks    <= r_sync1;
        end
    end

    assign w_any = |r_ks;

    // Priority encoder: the highest-index pressed key wins
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (r_ks[i]) begin
                w_cand = CODE_W'(i);
            end
        end
    end

    // Debouncer state, stability counter and latched candidate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Next-state logic; disabling aborts any press in progress without an event
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_push      = 1'b0;
        if (enablen) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        w_state_nxt = ST_DEBOUNCE;
                        w_cnt_nxt   = CNT_ONE;
                        w_cand_nxt  = w_cand;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_any) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_cand != r_cand) begin
                        w_cand_nxt = w_cand;
                        w_cnt_nxt  = CNT_ONE;
                    end else if (r_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!w_any) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (w_any) begin
                        w_state_nxt = ST_HELD;
                    end else if (r_cnt == CNT_MAX) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign V       = !w_empty;
    assign w_pop   = V && ready;
    assign pressed = (r_state == ST_HELD);

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (r_cand),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (D),
        .empty (w_empty),
        .drop  (overflow)
    );

endmodule
